// File: rtl/fader_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : fader_ctrl
//  Purpose  : Frame scheduler for a multi-channel fader. A free-running tick
//             counter paces frames; each frame issues a one-clock start with
//             a stable time index, then collects NCHAN in-order channel beats
//             from the fader. Frame completion advances the time index and
//             the frame counter. Sticky flags report dropped ticks (overrun),
//             out-of-order or unexpected beats (seq_err) and watchdog
//             timeouts (tmo).
//
//  Ports    : clk, reset (async, active-high)
//             enable, interval[15:0], t_step[24:0], err_clr   - control
//             start, t_index[24:0]                            - to fader
//             dv_in, chan_in[4:0]                             - from fader
//             busy, frame_done, frame_cnt[15:0],
//             overrun, seq_err, tmo                           - status
//
//  Options  : define FADER_CTRL_WDOG_EN to enable the collect watchdog
//             (TMO_CYC clocks from start). Without it tmo is tied low and a
//             frame waits indefinitely for its beats.
//
//  Revision : 1.0  initial release
// ============================================================================
module fader_ctrl #(
  parameter int NCHAN   = 32,
  parameter int TMO_CYC = 4096
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        enable,
  input  logic [15:0] interval,
  input  logic [24:0] t_step,
  input  logic        err_clr,
  output logic        start,
  output logic [24:0] t_index,
  input  logic        dv_in,
  input  logic [4:0]  chan_in,
  output logic        busy,
  output logic        frame_done,
  output logic [15:0] frame_cnt,
  output logic        overrun,
  output logic        seq_err,
  output logic        tmo
);

  localparam logic [4:0] LAST_BEAT = 5'(NCHAN - 1);

  if (NCHAN < 2 || NCHAN > 32 || TMO_CYC < 2) begin : g_param_check
    $error("fader_ctrl: NCHAN must be 2..32 and TMO_CYC at least 2");
  end

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_ISSUE   = 2'd1,
    S_COLLECT = 2'd2
  } state_t;

  state_t      state;
  logic [15:0] tcnt;
  logic [4:0]  beat;
  logic        tick;
  logic        last_beat;
  logic        overrun_set;
  logic        seq_set;
  logic        tmo_set;

  assign tick      = enable && (tcnt == interval);
  assign last_beat = (state == S_COLLECT) && dv_in && (beat == LAST_BEAT);

  // A tick that arrives while a frame is outstanding is dropped, not queued.
  assign overrun_set = tick && (state != S_IDLE);

  // Any beat outside COLLECT is unexpected; inside COLLECT it must be in order.
  assign seq_set = dv_in && ((state != S_COLLECT) || (chan_in != beat));

`ifdef FADER_CTRL_WDOG_EN
  localparam int             WD_W    = $clog2(TMO_CYC + 1);
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(TMO_CYC - 1);

  // wd holds clocks elapsed since the start pulse; it is 1 on the first
  // COLLECT clock, so expiry at WD_LAST raises tmo TMO_CYC clocks after start.
  logic [WD_W-1:0] wd;

  assign tmo_set = (state == S_COLLECT) && !last_beat && (wd == WD_LAST);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wd  <= '0;
      tmo <= 1'b0;
    end else begin
      if (state == S_ISSUE)
        wd <= WD_W'(1);
      else if (state == S_COLLECT)
        wd <= wd + WD_W'(1);

      if (tmo_set)
        tmo <= 1'b1;
      else if (err_clr)
        tmo <= 1'b0;
    end
  end
`else
  assign tmo_set = 1'b0;
  assign tmo     = 1'b0;
`endif

  // Tick counter: held at zero while disabled, wraps at interval.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      tcnt <= '0;
    else if (!enable || tick)
      tcnt <= '0;
    else
      tcnt <= tcnt + 16'd1;
  end

  // Sticky error flags; a set event in the same clock beats err_clr.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      overrun <= 1'b0;
      seq_err <= 1'b0;
    end else begin
      if (overrun_set)
        overrun <= 1'b1;
      else if (err_clr)
        overrun <= 1'b0;

      if (seq_set)
        seq_err <= 1'b1;
      else if (err_clr)
        seq_err <= 1'b0;
    end
  end

  // Frame FSM with registered outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= S_IDLE;
      beat       <= '0;
      start      <= 1'b0;
      busy       <= 1'b0;
      frame_done <= 1'b0;
      frame_cnt  <= '0;
      t_index    <= '0;
    end else begin
      start      <= 1'b0;
      frame_done <= 1'b0;

      // Advance one clock after the last beat so t_index stays stable
      // through the frame_done cycle; a start issued from that same cycle
      // already sees the new value.
      if (frame_done)
        t_index <= t_index + t_step;

      case (state)
        S_IDLE: begin
          if (tick) begin
            state <= S_ISSUE;
            start <= 1'b1;
            busy  <= 1'b1;
          end
        end
        S_ISSUE: begin
          state <= S_COLLECT;
          beat  <= '0;
        end
        S_COLLECT: begin
          if (last_beat) begin
            state      <= S_IDLE;
            busy       <= 1'b0;
            beat       <= '0;
            frame_done <= 1'b1;
            frame_cnt  <= frame_cnt + 16'd1;
          end else if (tmo_set) begin
            state <= S_IDLE;
            busy  <= 1'b0;
            beat  <= '0;
          end else if (dv_in) begin
            beat <= beat + 5'd1;
          end
        end
        default: begin
          state <= S_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_fader_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_fader_ctrl
//  Purpose  : Directed self-checking bench for fader_ctrl. A scripted fader
//             model answers each start with channel beats; expected values
//             are hand-derived constants.
//  Revision : 1.0  initial release
// ============================================================================
module tb_fader_ctrl;

  logic        clk;
  logic        reset;
  logic        enable;
  logic [15:0] interval;
  logic [24:0] t_step;
  logic        err_clr;
  logic        start;
  logic [24:0] t_index;
  logic        dv_in;
  logic [4:0]  chan_in;
  logic        busy;
  logic        frame_done;
  logic [15:0] frame_cnt;
  logic        overrun;
  logic        seq_err;
  logic        tmo;

  int checks     = 0;
  int failures   = 0;
  int cyc        = 0;
  int last_start = 0;
  int prev_start = 0;
  bit saw        = 1'b0;

  fader_ctrl #(
    .NCHAN   (32),
    .TMO_CYC (64)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .enable     (enable),
    .interval   (interval),
    .t_step     (t_step),
    .err_clr    (err_clr),
    .start      (start),
    .t_index    (t_index),
    .dv_in      (dv_in),
    .chan_in    (chan_in),
    .busy       (busy),
    .frame_done (frame_done),
    .frame_cnt  (frame_cnt),
    .overrun    (overrun),
    .seq_err    (seq_err),
    .tmo        (tmo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL global_timeout: got sim_time=%0t required finish earlier", $time);
    $fatal(1, "bench time limit reached");
  end

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  // Advance one clock and settle just after the edge.
  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic wait_start(input int budget);
    int n = 0;
    while (start !== 1'b1 && n < budget) begin
      step();
      n++;
    end
    check("start_seen", {31'd0, start}, 32'd1);
    last_start = cyc;
  endtask

  // Fader model, entered in the start (ISSUE) cycle. With skip set the
  // channel sequence runs 0,1,3,4,... so beat 2 is the first bad one.
  task automatic feed(input int nbeats, input int delay, input bit skip);
    step();
    repeat (delay) step();
    for (int k = 0; k < nbeats; k++) begin
      dv_in   = 1'b1;
      chan_in = (skip && k >= 2) ? 5'(k + 1) : 5'(k);
      step();
      if (skip && k == 1) check("seq_ok_beat1", {31'd0, seq_err}, 32'd0);
      if (skip && k == 2) check("seq_err_beat2", {31'd0, seq_err}, 32'd1);
    end
    dv_in   = 1'b0;
    chan_in = 5'd0;
  endtask

  initial begin
    reset    = 1'b1;
    enable   = 1'b0;
    interval = 16'd0;
    t_step   = 25'd0;
    err_clr  = 1'b0;
    dv_in    = 1'b0;
    chan_in  = 5'd0;
    repeat (3) step();

    // Reset state
    check("rst_flags", {26'd0, start, busy, frame_done, overrun, seq_err, tmo}, 32'd0);
    check("rst_t_index", {7'd0, t_index}, 32'd0);
    check("rst_frame_cnt", {16'd0, frame_cnt}, 32'd0);
    reset = 1'b0;
    step();

    // Stray beat in IDLE, set-over-clear priority, then clear
    dv_in = 1'b1;
    step();
    dv_in = 1'b0;
    check("seq_err_idle_beat", {31'd0, seq_err}, 32'd1);
    dv_in   = 1'b1;
    err_clr = 1'b1;
    step();
    dv_in = 1'b0;
    check("seq_err_set_wins", {31'd0, seq_err}, 32'd1);
    step();
    err_clr = 1'b0;
    check("seq_err_cleared", {31'd0, seq_err}, 32'd0);
    check("idle_not_busy", {31'd0, busy}, 32'd0);

    // Nominal frames: period 100, t_index 0,1000,2000; drop enable in frame 3
    interval = 16'd99;
    t_step   = 25'd1000;
    enable   = 1'b1;
    for (int f = 0; f < 3; f++) begin
      wait_start(150);
      check("t_index_at_start", {7'd0, t_index}, 1000 * f);
      check("busy_in_issue", {31'd0, busy}, 32'd1);
      if (f > 0) check("start_period_100", last_start - prev_start, 32'd100);
      prev_start = last_start;
      if (f == 2) enable = 1'b0;
      feed(32, 0, 1'b0);
      check("frame_done_high", {31'd0, frame_done}, 32'd1);
      check("t_index_stable_done", {7'd0, t_index}, 1000 * f);
      check("frame_cnt", {16'd0, frame_cnt}, f + 1);
      check("busy_after_frame", {31'd0, busy}, 32'd0);
      step();
      check("frame_done_one_clk", {31'd0, frame_done}, 32'd0);
      check("t_index_advanced", {7'd0, t_index}, 1000 * (f + 1));
    end
    check("nominal_no_flags", {29'd0, overrun, seq_err, tmo}, 32'd0);
    saw = 1'b0;
    repeat (250) begin
      step();
      if (start) saw = 1'b1;
    end
    check("no_start_when_disabled", {31'd0, saw}, 32'd0);

    // Out-of-order channel frame still completes
    enable = 1'b1;
    wait_start(150);
    feed(32, 0, 1'b1);
    check("seq_frame_completes", {31'd0, frame_done}, 32'd1);
    check("seq_err_sticky", {31'd0, seq_err}, 32'd1);
    enable = 1'b0;
    step();
    err_clr = 1'b1;
    step();
    err_clr = 1'b0;
    check("seq_err_pulse_clr", {31'd0, seq_err}, 32'd0);

    // Overrun: ticks every 10, frame spans 40 clocks -> start every 50
    reset = 1'b1;
    step();
    reset    = 1'b0;
    interval = 16'd9;
    t_step   = 25'd5;
    enable   = 1'b1;
    for (int f = 0; f < 3; f++) begin
      wait_start(60);
      check("ovr_t_index_at_start", {7'd0, t_index}, 5 * f);
      if (f > 0) check("ovr_start_period_50", last_start - prev_start, 32'd50);
      prev_start = last_start;
      feed(32, 7, 1'b0);
      check("ovr_frame_done", {31'd0, frame_done}, 32'd1);
      step();
    end
    enable = 1'b0;
    check("overrun_set", {31'd0, overrun}, 32'd1);
    check("ovr_frame_cnt", {16'd0, frame_cnt}, 32'd3);
    check("ovr_t_index", {7'd0, t_index}, 32'd15);
    err_clr = 1'b1;
    step();
    err_clr = 1'b0;
    check("overrun_cleared", {31'd0, overrun}, 32'd0);

    // t_index wraps modulo 2^25
    reset = 1'b1;
    step();
    reset    = 1'b0;
    interval = 16'd99;
    t_step   = 25'h1FFFF00;
    enable   = 1'b1;
    wait_start(150);
    feed(32, 0, 1'b0);
    step();
    check("t_index_pre_wrap", {7'd0, t_index}, 32'h01FFFF00);
    t_step = 25'h200;
    wait_start(150);
    check("t_index_start_pre_wrap", {7'd0, t_index}, 32'h01FFFF00);
    feed(32, 0, 1'b0);
    check("wrap_frame_done", {31'd0, frame_done}, 32'd1);
    step();
    check("t_index_wrapped", {7'd0, t_index}, 32'h00000100);
    enable = 1'b0;
    step();

    // Stalled frame: watchdog timeout (when built in), then async reset
    interval = 16'd199;
    enable   = 1'b1;
`ifdef FADER_CTRL_WDOG_EN
    wait_start(250);
    prev_start = last_start;
    feed(10, 0, 1'b0);
    saw = 1'b0;
    for (int n = 0; n < 200 && tmo !== 1'b1; n++) begin
      step();
      if (frame_done) saw = 1'b1;
    end
    check("tmo_latency_64", cyc - prev_start, 32'd64);
    check("tmo_forces_idle", {31'd0, busy}, 32'd0);
    check("tmo_no_frame_done", {31'd0, saw}, 32'd0);
    check("tmo_t_index_kept", {7'd0, t_index}, 32'h00000100);
    check("tmo_frame_cnt_kept", {16'd0, frame_cnt}, 32'd2);
`endif
    wait_start(250);
    check("reissue_t_index", {7'd0, t_index}, 32'h00000100);
    feed(10, 0, 1'b0);
    check("busy_mid_collect", {31'd0, busy}, 32'd1);
    #2;
    reset = 1'b1;
    #1;
    check("async_rst_flags", {26'd0, start, busy, frame_done, overrun, seq_err, tmo}, 32'd0);
    check("async_rst_t_index", {7'd0, t_index}, 32'd0);
    check("async_rst_frame_cnt", {16'd0, frame_cnt}, 32'd0);
    step();
    step();
    reset = 1'b0;
    saw   = 1'b0;
    for (int n = 0; n < 250 && start !== 1'b1; n++) begin
      step();
      if (frame_done) saw = 1'b1;
    end
    check("post_rst_start", {31'd0, start}, 32'd1);
    check("post_rst_no_frame_done", {31'd0, saw}, 32'd0);
    check("post_rst_t_index", {7'd0, t_index}, 32'd0);
    check("tmo_low_at_end", {31'd0, tmo}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
